wm8731_spi_init_seq: RTL and testbench

//  Power-up configuration sequencer for the WM8731 codec over its 3-wire SPI control port.
//  - Walks the 11-entry codec init register table at addresses 0..NUM_REGS-1.
//  - The table is a combinational ROM: {7-bit reg addr, 9-bit value}.
//  - Serialises each 16-bit word MSB-first and latches it with a CSB rising edge.
//  - Sits between the system reset/start logic and the IIS audio path; the IIS block waits for done.

---
 rtl/wm8731_spi_init_seq.sv | 185 ++++++++++++++++++
 tb/tb_wm8731_spi_init_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_spi_init_seq.sv
// wm8731_spi_init_seq: power-up register sequencer for the WM8731 3-wire control port.
// Walks an external combinational register ROM (addresses 0..NUM_REGS-1). Each
// 16-bit {reg addr, value} word is shifted out MSB-first on SDIN/SCLK and latched
// in the codec by the CSB rising edge.
// Build option: define WM8731_POST_RESET_WAIT_EN to pause POST_RESET_CYCLES clocks
// after word 0 (the codec reset write) before the rest of the table is sent.
module wm8731_spi_init_seq #(
    parameter int CLK_DIV           = 4,
    parameter int NUM_REGS          = 11,
    parameter int POST_RESET_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        spi_csb,
    output logic        spi_sclk,
    output logic        spi_sdin,
    output logic        busy,
    output logic        done
);

    // One SCLK period spans 2*CLK_DIV clocks; the same counter times LATCH and GAP.
    localparam int               DIV_W     = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] HALF      = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [7:0]       LAST_ADDR = 8'(NUM_REGS - 1);

`ifdef WM8731_POST_RESET_WAIT_EN
    localparam int                WAIT_W    = $clog2(POST_RESET_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POST_RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_GAP,
        S_RWAIT,
        S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_GAP,
        S_DONE
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [7:0]       rom_addr_q, rom_addr_d;
    logic [15:0]      sreg_q, sreg_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
`ifdef WM8731_POST_RESET_WAIT_EN
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    // State and datapath registers; async reset returns everything to an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            sreg_q     <= '0;
            div_q      <= '0;
            bit_q      <= '0;
`ifdef WM8731_POST_RESET_WAIT_EN
            wait_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            sreg_q     <= sreg_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
`ifdef WM8731_POST_RESET_WAIT_EN
            wait_q     <= wait_d;
`endif
        end
    end

    // Next-state, counter updates and the SPI pin levels for each state.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        sreg_d     = sreg_q;
        div_d      = div_q;
        bit_d      = bit_q;
`ifdef WM8731_POST_RESET_WAIT_EN
        wait_d     = wait_q;
`endif
        spi_csb    = 1'b1;
        spi_sclk   = 1'b0;
        spi_sdin   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    rom_addr_d = '0;
                end
            end

            S_LOAD: begin
                spi_csb = 1'b0;
                sreg_d  = rom_data;
                div_d   = '0;
                bit_d   = '0;
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                spi_csb  = 1'b0;
                spi_sclk = (div_q >= HALF);
                spi_sdin = sreg_q[15];
                if (div_q == BIT_LAST) begin
                    // SCLK falling edge: present the next bit
                    div_d  = '0;
                    sreg_d = {sreg_q[14:0], 1'b0};
                    bit_d  = bit_q + 5'd1;
                    if (bit_q == 5'd15) begin
                        state_d = S_LATCH;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_LATCH: begin
                spi_csb = 1'b0;
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    state_d = S_GAP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_GAP: begin
                if (div_q == HALF_LAST) begin
                    div_d = '0;
                    if (rom_addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
`ifdef WM8731_POST_RESET_WAIT_EN
                    end else if (rom_addr_q == 8'd0) begin
                        // give the codec time to recover from its reset write
                        wait_d  = '0;
                        state_d = S_RWAIT;
`endif
                    end else begin
                        rom_addr_d = rom_addr_q + 8'd1;
                        state_d    = S_LOAD;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

`ifdef WM8731_POST_RESET_WAIT_EN
            S_RWAIT: begin
                if (wait_q == WAIT_LAST) begin
                    rom_addr_d = 8'd1;
                    state_d    = S_LOAD;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom_addr = rom_addr_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_wm8731_spi_init_seq.sv
// tb_wm8731_spi_init_seq: bench for the WM8731 SPI init sequencer. Provides the
// register ROM, a cycle-sampled codec model capturing each latched word, and
// arithmetic expectations for word content, bit timing and sequence duration.
module tb_wm8731_spi_init_seq;

    localparam int CLK_DIV  = 4;
    localparam int NUM_REGS = 11;
`ifdef WM8731_POST_RESET_WAIT_EN
    localparam int POST = 1024;
`else
    localparam int POST = 0;
`endif
    localparam int WORD_CYC  = 1 + 34 * CLK_DIV;
    localparam int EXP_TOTAL = NUM_REGS * WORD_CYC + POST;
    localparam int CSB_LOW   = 1 + 33 * CLK_DIV;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        spi_csb;
    logic        spi_sclk;
    logic        spi_sdin;
    logic        busy;
    logic        done;

    wm8731_spi_init_seq #(
        .CLK_DIV          (CLK_DIV),
        .NUM_REGS         (NUM_REGS),
        .POST_RESET_CYCLES(1024)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .spi_csb (spi_csb),
        .spi_sclk(spi_sclk),
        .spi_sdin(spi_sdin),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Codec init table
    function automatic logic [15:0] rom_word(input int i);
        case (i)
            0:       return 16'h1E00;
            1:       return 16'h0017;
            2:       return 16'h0217;
            3:       return 16'h0479;
            4:       return 16'h0679;
            5:       return 16'h0810;
            6:       return 16'h0A00;
            7:       return 16'h0C00;
            8:       return 16'h0E53;
            9:       return 16'h1000;
            10:      return 16'h1201;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign rom_data = rom_word(int'(rom_addr));

    // ---------------- scoreboard counters ----------------
    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- codec model (sampled once per clock) ----------------
    logic        rec_en;
    int          smp_cyc;
    logic        prev_csb, prev_sclk, prev_sdin;
    logic [15:0] shreg;
    int          rises, unstable;
    int          fall_q[$];
    int          rise_q[$];
    logic [15:0] words_q[$];
    int          rises_q[$];
    int          unstable_q[$];

    initial begin
        smp_cyc   = 0;
        prev_csb  = 1'b1;
        prev_sclk = 1'b0;
        prev_sdin = 1'b0;
        shreg     = '0;
        rises     = 0;
        unstable  = 0;
    end

    always @(negedge clk) begin
        smp_cyc++;
        if (rec_en) begin
            if (prev_csb && !spi_csb) begin
                fall_q.push_back(smp_cyc);
                rises    = 0;
                unstable = 0;
                shreg    = '0;
            end
            if (!spi_csb) begin
                if (!prev_sclk && spi_sclk) begin
                    rises++;
                    shreg = {shreg[14:0], spi_sdin};
                    if (spi_sdin !== prev_sdin) unstable++;
                end else if (prev_sclk && spi_sclk && (spi_sdin !== prev_sdin)) begin
                    unstable++;
                end
            end
            if (!prev_csb && spi_csb) begin
                rise_q.push_back(smp_cyc);
                words_q.push_back(shreg);
                rises_q.push_back(rises);
                unstable_q.push_back(unstable);
            end
        end
        prev_csb  = spi_csb;
        prev_sclk = spi_sclk;
        prev_sdin = spi_sdin;
    end

    task automatic clear_rec();
        fall_q.delete();
        rise_q.delete();
        words_q.delete();
        rises_q.delete();
        unstable_q.delete();
        rec_en = 1'b1;
    endtask

    // ---------------- expected per-word records ----------------
    typedef struct {
        int          idx;
        logic [15:0] word;
        int          csb_low;
        int          rises;
        int          gap_before;
    } word_vec_t;

    word_vec_t vec[NUM_REGS];

    // One start pulse, optional start pulses while busy, then measure done time.
    task automatic run_seq(input int inj0, input int inj1, input string tag);
        int done_k;
        int prev_addr;
        int walk_bad;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_at_load"}, busy, 1);
        chk({tag, "_done_cleared"}, done, 0);
        chk({tag, "_addr_at_load"}, rom_addr, 0);
        done_k    = -1;
        prev_addr = 0;
        walk_bad  = 0;
        for (int k = 0; k <= EXP_TOTAL + 100; k++) begin
            if (done) begin
                done_k = k;
                break;
            end
            if (!busy) walk_bad++;
            if (int'(rom_addr) != prev_addr && int'(rom_addr) != prev_addr + 1) walk_bad++;
            if (int'(rom_addr) > NUM_REGS - 1) walk_bad++;
            prev_addr = int'(rom_addr);
            start = (k == inj0) || (k == inj1);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, done_k, EXP_TOTAL);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_addr_at_done"}, rom_addr, NUM_REGS - 1);
        chk({tag, "_addr_walk_errs"}, walk_bad, 0);
    endtask

    // Compare what the codec captured against the expected word table.
    task automatic verify(input string tag);
        rec_en = 1'b0;
        chk({tag, "_word_count"}, words_q.size(), NUM_REGS);
        for (int i = 0; i < NUM_REGS && i < words_q.size(); i++) begin
            chk($sformatf("%s_w%0d_data", tag, vec[i].idx), words_q[i], vec[i].word);
            chk($sformatf("%s_w%0d_sclk_rises", tag, vec[i].idx), rises_q[i], vec[i].rises);
            chk($sformatf("%s_w%0d_sdin_unstable", tag, vec[i].idx), unstable_q[i], 0);
            chk($sformatf("%s_w%0d_csb_low", tag, vec[i].idx), rise_q[i] - fall_q[i], vec[i].csb_low);
            if (i > 0) begin
                chk($sformatf("%s_w%0d_csb_gap", tag, vec[i].idx), fall_q[i] - rise_q[i-1],
                    vec[i].gap_before);
            end
        end
    endtask

    initial begin
        int guard;
        n_cmp  = 0;
        n_bad  = 0;
        start  = 1'b0;
        rst_n  = 1'b0;
        rec_en = 1'b0;

        for (int i = 0; i < NUM_REGS; i++) begin
            vec[i].idx        = i;
            vec[i].word       = rom_word(i);
            vec[i].csb_low    = CSB_LOW;
            vec[i].rises      = 16;
            vec[i].gap_before = CLK_DIV + ((i == 1) ? POST : 0);
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_csb", spi_csb, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_sdin", spi_sdin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of word 2 with SCLK high
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * WORD_CYC + POST + 40) @(negedge clk);
        guard = 0;
        while (!spi_sclk && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("t1_sclk_high_before_rst", spi_sclk, 1);
        chk("t1_addr_before_rst", rom_addr, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_csb", spi_csb, 1);
        chk("t1_sclk", spi_sclk, 0);
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        chk("t1_addr", rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_stays_idle", busy, 0);

        // Full sequence
        clear_rec();
        run_seq(-1, -1, "full");
        verify("full");

        // Start pulses during word 5 and during the final gap are ignored
        clear_rec();
        run_seq(5 * WORD_CYC + POST + 60, EXP_TOTAL - 1, "busy_start");
        verify("busy_start");

        // Restart straight from DONE
        chk("pre_restart_done", done, 1);
        clear_rec();
        run_seq(-1, -1, "restart");
        verify("restart");

        // Randomised idle time and stray start pulses while busy
        for (int r = 0; r < 3; r++) begin
            int idle;
            int i0;
            int i1;
            idle = int'($urandom_range(0, 20));
            i0   = int'($urandom_range(1, EXP_TOTAL - 1));
            i1   = int'($urandom_range(1, EXP_TOTAL - 1));
            repeat (idle) @(negedge clk);
            clear_rec();
            run_seq(i0, i1, $sformatf("rnd%0d", r));
            verify($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
